// File: rtl/roberto_limiar.sv
// Threshold parser and proximity alert generator.
// Parses '#' d2 d1 d0 ASCII frames into a BCD distance threshold and raises a
// per-sensor alert after N_CONSEC consecutive measurements below it.
//
// state    | meaning
// ESPERA   | idle, waiting for '#'
// DIG_C    | waiting for hundreds digit
// DIG_D    | waiting for tens digit
// DIG_U    | waiting for units digit
// ATUALIZA | one cycle, commits the complete frame to limiar
module roberto_limiar #(
    parameter int          N_CONSEC      = 3,
    parameter logic [11:0] LIMIAR_PADRAO = 12'h020,
    parameter int          TIMEOUT       = 1_000_000,
    parameter int          W_TIMEOUT     = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        rx_pronto,
    input  logic [6:0]  rx_dado,
    input  logic        medida_pronto,
    input  logic [11:0] medida1,
    input  logic [11:0] medida2,
    input  logic [11:0] medida3,
    output logic [11:0] limiar,
    output logic        limiar_novo,
    output logic        erro_cmd,
    output logic [2:0]  alerta,
    output logic [3:0]  db_estado
);

    localparam int                   CW       = $clog2(N_CONSEC + 1);
    localparam logic [CW-1:0]        CONT_MAX = CW'(N_CONSEC);
    localparam logic [W_TIMEOUT-1:0] TMO_FIM  = W_TIMEOUT'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        DIG_C    = 3'd1,
        DIG_D    = 3'd2,
        DIG_U    = 3'd3,
        ATUALIZA = 3'd4
    } estado_t;

    estado_t              estado, estado_nxt;
    logic                 erro_nxt;
    logic [W_TIMEOUT-1:0] tmo;
    logic [3:0]           dig_c, dig_d, dig_u;
    logic                 e_hash, e_digito, em_digito, tmo_fim;

    logic [11:0]   medida   [3];
    logic [CW-1:0] cont     [3];
    logic [CW-1:0] cont_nxt [3];

    assign e_hash    = (rx_dado == 7'h23);
    assign e_digito  = (rx_dado >= 7'h30) && (rx_dado <= 7'h39);
    assign em_digito = (estado == DIG_C) || (estado == DIG_D) || (estado == DIG_U);
    // rx_pronto in the terminal cycle wins over the timeout
    assign tmo_fim   = em_digito && !rx_pronto && (tmo == TMO_FIM);
    assign db_estado = {1'b0, estado};

    assign medida[0] = medida1;
    assign medida[1] = medida2;
    assign medida[2] = medida3;

    function automatic logic bcd_ok(input logic [11:0] m);
        return (m[11:8] <= 4'd9) && (m[7:4] <= 4'd9) && (m[3:0] <= 4'd9);
    endfunction

    // Parser state and error pulse registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= ESPERA;
            erro_cmd <= 1'b0;
        end else if (zera) begin
            estado   <= ESPERA;
            erro_cmd <= 1'b0;
        end else begin
            estado   <= estado_nxt;
            erro_cmd <= erro_nxt;
        end
    end

    // Parser next-state and error decision
    always_comb begin
        estado_nxt = estado;
        erro_nxt   = 1'b0;
        case (estado)
            ESPERA: begin
                if (rx_pronto && e_hash) estado_nxt = DIG_C;
            end
            DIG_C, DIG_D, DIG_U: begin
                if (rx_pronto) begin
                    if (e_digito) begin
                        case (estado)
                            DIG_C:   estado_nxt = DIG_D;
                            DIG_D:   estado_nxt = DIG_U;
                            default: estado_nxt = ATUALIZA;
                        endcase
                    end else if (e_hash) begin
                        estado_nxt = DIG_C;
                        erro_nxt   = 1'b1;
                    end else begin
                        estado_nxt = ESPERA;
                        erro_nxt   = 1'b1;
                    end
                end else if (tmo_fim) begin
                    estado_nxt = ESPERA;
                    erro_nxt   = 1'b1;
                end
            end
            ATUALIZA: estado_nxt = ESPERA;
            default:  estado_nxt = ESPERA;
        endcase
    end

    // Digit holding registers, inter-char timer and threshold commit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dig_c       <= 4'd0;
            dig_d       <= 4'd0;
            dig_u       <= 4'd0;
            tmo         <= '0;
            limiar      <= LIMIAR_PADRAO;
            limiar_novo <= 1'b0;
        end else if (zera) begin
            dig_c       <= 4'd0;
            dig_d       <= 4'd0;
            dig_u       <= 4'd0;
            tmo         <= '0;
            limiar      <= LIMIAR_PADRAO;
            limiar_novo <= 1'b0;
        end else begin
            if (rx_pronto && e_digito) begin
                if (estado == DIG_C) dig_c <= rx_dado[3:0];
                if (estado == DIG_D) dig_d <= rx_dado[3:0];
                if (estado == DIG_U) dig_u <= rx_dado[3:0];
            end
            if (!em_digito || rx_pronto) tmo <= '0;
            else                         tmo <= tmo + W_TIMEOUT'(1);
            if (estado == ATUALIZA) limiar <= {dig_c, dig_d, dig_u};
            limiar_novo <= (estado == ATUALIZA);
        end
    end

    // Saturating below-threshold counters; compare uses limiar before any same-edge update
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cont_nxt[i] = cont[i];
            if (medida_pronto) begin
                if (bcd_ok(medida[i]) && (medida[i] < limiar))
                    cont_nxt[i] = (cont[i] == CONT_MAX) ? CONT_MAX : cont[i] + CW'(1);
                else
                    cont_nxt[i] = '0;
            end
        end
    end

    // Counter and alert registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) cont[i] <= '0;
            alerta <= 3'b000;
        end else if (zera) begin
            for (int i = 0; i < 3; i++) cont[i] <= '0;
            alerta <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cont[i]   <= cont_nxt[i];
                alerta[i] <= (cont_nxt[i] == CONT_MAX);
            end
        end
    end

endmodule

// File: tb/tb_roberto_limiar.sv
// Directed bench for roberto_limiar: parser events go through an expected-event
// queue checked by a monitor; alerts are checked against a small counter model.
module tb_roberto_limiar;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        zera = 1'b0;
    logic        rx_pronto = 1'b0;
    logic [6:0]  rx_dado = 7'h00;
    logic        medida_pronto = 1'b0;
    logic [11:0] medida1 = 12'h999;
    logic [11:0] medida2 = 12'h999;
    logic [11:0] medida3 = 12'h999;
    logic [11:0] limiar;
    logic        limiar_novo;
    logic        erro_cmd;
    logic [2:0]  alerta;
    logic [3:0]  db_estado;

    roberto_limiar #(
        .N_CONSEC(3), .LIMIAR_PADRAO(12'h020), .TIMEOUT(TMO), .W_TIMEOUT(5)
    ) dut (
        .clock(clock), .reset(reset), .zera(zera),
        .rx_pronto(rx_pronto), .rx_dado(rx_dado),
        .medida_pronto(medida_pronto),
        .medida1(medida1), .medida2(medida2), .medida3(medida3),
        .limiar(limiar), .limiar_novo(limiar_novo), .erro_cmd(erro_cmd),
        .alerta(alerta), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        novo;
        logic        erro;
        logic [11:0] lim;
    } ev_t;

    ev_t         exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cont_m[3] = '{0, 0, 0};
    logic [11:0] lim_m = 12'h020;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Every limiar_novo/erro_cmd pulse must match the oldest expected event
    always @(negedge clock) begin
        if (reset && (limiar_novo || erro_cmd)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({limiar_novo, erro_cmd, limiar}), 32'h0);
            end else begin
                check("event", 32'({limiar_novo, erro_cmd, limiar}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [6:0] c);
        rx_dado   = c;
        rx_pronto = 1'b1;
        tick();
        rx_pronto = 1'b0;
    endtask

    function automatic logic bcd_valid(input logic [11:0] m);
        return (m[11:8] < 4'd10) && (m[7:4] < 4'd10) && (m[3:0] < 4'd10);
    endfunction

    task automatic meas(input logic [11:0] m1, input logic [11:0] m2, input logic [11:0] m3);
        logic [11:0] m[3];
        logic [2:0]  a;
        m[0] = m1; m[1] = m2; m[2] = m3;
        medida1 = m1; medida2 = m2; medida3 = m3;
        for (int i = 0; i < 3; i++) begin
            if (bcd_valid(m[i]) && (m[i] < lim_m)) cont_m[i] = (cont_m[i] >= 3) ? 3 : cont_m[i] + 1;
            else cont_m[i] = 0;
            a[i] = (cont_m[i] == 3);
        end
        medida_pronto = 1'b1;
        tick();
        medida_pronto = 1'b0;
        check("alerta", 32'(alerta), 32'(a));
    endtask

    initial begin
        // 1: reset state
        #12;
        check("rst_limiar", 32'(limiar), 32'h020);
        check("rst_alerta", 32'(alerta), 32'h0);
        check("rst_estado", 32'(db_estado), 32'h0);
        check("rst_pulses", 32'({limiar_novo, erro_cmd}), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (10) tick();

        // 2: good frame 150
        send(7'h23); send(7'h31); send(7'h35);
        exp_q.push_back('{1'b1, 1'b0, 12'h150});
        send(7'h30);
        repeat (3) tick();
        lim_m = 12'h150;
        check("f150_limiar", 32'(limiar), 32'h150);
        check("f150_drained", 32'(exp_q.size()), 32'h0);

        // 3: bad char aborts frame
        send(7'h23); send(7'h31);
        check("mid_estado", 32'(db_estado), 32'h2);
        exp_q.push_back('{1'b0, 1'b1, 12'h150});
        send(7'h41);
        check("bad_estado", 32'(db_estado), 32'h0);
        repeat (2) tick();
        check("bad_limiar", 32'(limiar), 32'h150);
        check("bad_drained", 32'(exp_q.size()), 32'h0);

        // 4a: silence times out
        send(7'h23); send(7'h32);
        exp_q.push_back('{1'b0, 1'b1, 12'h150});
        repeat (TMO + 4) tick();
        check("tmo_estado", 32'(db_estado), 32'h0);
        check("tmo_drained", 32'(exp_q.size()), 32'h0);

        // 4b: '#' mid-frame restarts it
        send(7'h23); send(7'h32);
        exp_q.push_back('{1'b0, 1'b1, 12'h150});
        send(7'h23);
        check("restart_estado", 32'(db_estado), 32'h1);
        send(7'h30); send(7'h35);
        exp_q.push_back('{1'b1, 1'b0, 12'h050});
        send(7'h30);
        repeat (3) tick();
        lim_m = 12'h050;
        check("f050_limiar", 32'(limiar), 32'h050);
        check("f050_drained", 32'(exp_q.size()), 32'h0);

        // 4c: a char landing in the terminal timeout cycle is still accepted
        send(7'h23); repeat (TMO - 1) tick();
        send(7'h30); repeat (TMO - 1) tick();
        send(7'h36); repeat (TMO - 1) tick();
        exp_q.push_back('{1'b1, 1'b0, 12'h060});
        send(7'h30);
        repeat (3) tick();
        check("edge_drained", 32'(exp_q.size()), 32'h0);
        send(7'h23); send(7'h30); send(7'h35);
        exp_q.push_back('{1'b1, 1'b0, 12'h050});
        send(7'h30);
        repeat (3) tick();
        lim_m = 12'h050;
        check("back050_limiar", 32'(limiar), 32'h050);

        // 5: consecutive-count alerts
        meas(12'h049, 12'h999, 12'h999);
        meas(12'h049, 12'h999, 12'h999);
        meas(12'h049, 12'h999, 12'h999);
        meas(12'h049, 12'h999, 12'h999);
        meas(12'h050, 12'h0A0, 12'h000);
        meas(12'h050, 12'h0A0, 12'h000);
        meas(12'h050, 12'h0A0, 12'h000);
        meas(12'h050, 12'h049, 12'h999);

        // 6a: threshold commit coincident with a measurement
        meas(12'h049, 12'h999, 12'h999);
        meas(12'h049, 12'h999, 12'h999);
        send(7'h23); send(7'h31); send(7'h30);
        exp_q.push_back('{1'b1, 1'b0, 12'h100});
        send(7'h30);
        meas(12'h070, 12'h999, 12'h999);
        lim_m = 12'h100;
        meas(12'h070, 12'h999, 12'h999);
        tick();
        check("coinc_limiar", 32'(limiar), 32'h100);
        check("coinc_drained", 32'(exp_q.size()), 32'h0);

        // 6b: synchronous clear
        meas(12'h000, 12'h000, 12'h000);
        meas(12'h000, 12'h000, 12'h000);
        meas(12'h000, 12'h000, 12'h000);
        zera = 1'b1; tick(); zera = 1'b0;
        cont_m = '{0, 0, 0};
        lim_m = 12'h020;
        check("zera_limiar", 32'(limiar), 32'h020);
        check("zera_alerta", 32'(alerta), 32'h0);

        // 6c: reset mid-frame discards partial digits
        send(7'h23); send(7'h37);
        #2 reset = 1'b0;
        #1;
        check("midrst_limiar", 32'(limiar), 32'h020);
        check("midrst_estado", 32'(db_estado), 32'h0);
        check("midrst_pulses", 32'({limiar_novo, erro_cmd}), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        send(7'h38); send(7'h39);
        repeat (4) tick();
        check("post_limiar", 32'(limiar), 32'h020);
        check("post_estado", 32'(db_estado), 32'h0);
        check("post_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
